// File: rtl/x3q16_mem_responder.sv
// x3q16 memory responder: owns the program counter and turns core requests into single-word
// req/ack bus transactions, returning each fetched or read word to the core.
module x3q16_mem_responder #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter logic [15:0] PROTECT_BASE = 16'hFF00,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        request,
   input  logic [1:0]  request_type,
   input  logic [15:0] request_address,
   input  logic [15:0] store_data,
   output logic [15:0] memory_in,
   output logic        memory_ready,
   output logic [15:0] current_address,
   output logic        memory_critical,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata
);

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {StBoot, StIdle, StWrite, StFetch, StRead} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] memory_in_q, memory_in_d;
   logic        memory_ready_q, memory_ready_d;
   logic [15:0] current_address_q, current_address_d;
   logic        memory_critical_q, memory_critical_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;

   logic ack_now, wait_cycle, expired;

   assign ack_now    = mem_req_q & mem_ack;
   assign wait_cycle = mem_req_q & ~mem_ack;
   // Ack on the expiry cycle takes priority because expired requires no ack.
   assign expired    = wait_cycle & (cnt_q == TimeoutLast);

   always_comb begin
      state_d           = state_q;
      pc_d              = pc_q;
      cnt_d             = cnt_q;
      memory_in_d       = memory_in_q;
      memory_ready_d    = memory_ready_q;
      current_address_d = current_address_q;
      memory_critical_d = 1'b0;
      mem_req_d         = mem_req_q;
      mem_we_d          = mem_we_q;
      mem_addr_d        = mem_addr_q;
      mem_wdata_d       = mem_wdata_q;

      if (wait_cycle) cnt_d = cnt_q + 8'd1;
      if (request && state_q != StIdle) memory_critical_d = 1'b1;

      unique case (state_q)
         StBoot: begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_q;
            cnt_d      = 8'd0;
            state_d    = StFetch;
         end
         StIdle: begin
            if (request) begin
               memory_ready_d = 1'b0;
               cnt_d          = 8'd0;
               mem_req_d      = 1'b1;
               mem_we_d       = 1'b0;
               case (request_type)
                  2'b00: begin
                     pc_d       = pc_q + 16'd1;
                     mem_addr_d = pc_q + 16'd1;
                     state_d    = StFetch;
                  end
                  2'b01: begin
                     mem_addr_d = request_address;
                     state_d    = StRead;
                  end
                  2'b10: begin
                     // Protected writes never reach the bus; WRITE then raises the fault.
                     mem_req_d   = (request_address < PROTECT_BASE);
                     mem_we_d    = (request_address < PROTECT_BASE);
                     mem_addr_d  = request_address;
                     mem_wdata_d = store_data;
                     state_d     = StWrite;
                  end
                  2'b11: begin
                     pc_d       = request_address;
                     mem_addr_d = request_address;
                     state_d    = StFetch;
                  end
               endcase
            end
         end
         StWrite: begin
            if (!mem_req_q || ack_now || expired) begin
               memory_critical_d = memory_critical_d | ~ack_now;
               mem_req_d         = 1'b0;
               mem_we_d          = 1'b0;
               pc_d              = pc_q + 16'd1;
               state_d           = StFetch;
            end
         end
         StFetch, StRead: begin
            if (!mem_req_q) begin
               // Second half of a write: the bus saw one idle cycle, now fetch pc.
               mem_req_d  = 1'b1;
               mem_addr_d = pc_q;
               cnt_d      = 8'd0;
            end else if (ack_now || expired) begin
               memory_in_d       = ack_now ? mem_rdata : 16'h0000;
               current_address_d = mem_addr_q;
               memory_critical_d = memory_critical_d | expired;
               mem_req_d         = 1'b0;
               memory_ready_d    = 1'b1;
               state_d           = StIdle;
            end
         end
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q           <= StBoot;
         pc_q              <= RESET_VECTOR;
         cnt_q             <= 8'd0;
         memory_in_q       <= 16'h0000;
         memory_ready_q    <= 1'b0;
         current_address_q <= 16'hFFFF;
         memory_critical_q <= 1'b0;
         mem_req_q         <= 1'b0;
         mem_we_q          <= 1'b0;
         mem_addr_q        <= 16'h0000;
         mem_wdata_q       <= 16'h0000;
      end else begin
         state_q           <= state_d;
         pc_q              <= pc_d;
         cnt_q             <= cnt_d;
         memory_in_q       <= memory_in_d;
         memory_ready_q    <= memory_ready_d;
         current_address_q <= current_address_d;
         memory_critical_q <= memory_critical_d;
         mem_req_q         <= mem_req_d;
         mem_we_q          <= mem_we_d;
         mem_addr_q        <= mem_addr_d;
         mem_wdata_q       <= mem_wdata_d;
      end
   end

   assign memory_in       = memory_in_q;
   assign memory_ready    = memory_ready_q;
   assign current_address = current_address_q;
   assign memory_critical = memory_critical_q;
   assign mem_req         = mem_req_q;
   assign mem_we          = mem_we_q;
   assign mem_addr        = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_x3q16_mem_responder.sv
// Bench for x3q16_mem_responder: vector table of core requests against a programmable bus
// responder, with bus transactions and returned words checked through scoreboard queues.
module tb_x3q16_mem_responder;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } bus_t;

   typedef struct {
      logic [15:0] data;
      logic [15:0] addr;
   } rsp_t;

   typedef struct {
      logic [1:0]  rtype;
      logic [15:0] addr;
      logic [15:0] data;
      int          waits;
      logic [15:0] rdata;
      bit          hold;
      bit          poke;
      bit          exp_write;
      logic [15:0] exp_fetch;
      logic [15:0] exp_in;
      logic [15:0] exp_cur;
      int          exp_crit;
      int          exp_lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        request = 1'b0;
   logic [1:0]  request_type = 2'b00;
   logic [15:0] request_address = 16'h0000;
   logic [15:0] store_data = 16'h0000;
   logic [15:0] memory_in;
   logic        memory_ready;
   logic [15:0] current_address;
   logic        memory_critical;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = 16'h0000;

   int checks = 0;
   int failures = 0;

   int          cfg_waits = 0;
   logic [15:0] cfg_rdata = 16'h0000;
   bit          cfg_hold = 1'b0;

   bus_t obs_log[64];
   int   obs_n = 0;
   int   obs_rd = 0;
   bit   in_txn = 1'b0;
   int   wait_left = 0;
   int   crit_total = 0;
   int   crit_base = 0;

   bus_t exp_bus_q[$];
   rsp_t exp_rsp_q[$];
   vec_t vecs[14];

   x3q16_mem_responder dut (
      .clk             (clk),
      .reset           (reset),
      .request         (request),
      .request_type    (request_type),
      .request_address (request_address),
      .store_data      (store_data),
      .memory_in       (memory_in),
      .memory_ready    (memory_ready),
      .current_address (current_address),
      .memory_critical (memory_critical),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_ack         (mem_ack),
      .mem_rdata       (mem_rdata)
   );

   always #5 clk = ~clk;

   // Bus responder: logs each new transaction and acks after cfg_waits wait cycles.
   always @(negedge clk) begin
      mem_ack = 1'b0;
      if (!mem_req) begin
         in_txn = 1'b0;
      end else begin
         if (!in_txn) begin
            in_txn    = 1'b1;
            wait_left = cfg_waits;
            if (obs_n < 64) begin
               obs_log[obs_n] = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
               obs_n = obs_n + 1;
            end
         end
         if (!cfg_hold) begin
            if (wait_left == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = cfg_rdata;
            end else begin
               wait_left = wait_left - 1;
            end
         end
      end
   end

   always @(negedge clk) if (memory_critical) crit_total = crit_total + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         failures = failures + 1;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] rt, input logic [15:0] a, input logic [15:0] d,
                               input int w, input logic [15:0] rd, input bit h, input bit p,
                               input bit ew, input logic [15:0] ef, input logic [15:0] ei,
                               input logic [15:0] ec, input int cr, input int lt);
      vec_t v;
      v = '{rtype: rt, addr: a, data: d, waits: w, rdata: rd, hold: h, poke: p, exp_write: ew,
            exp_fetch: ef, exp_in: ei, exp_cur: ec, exp_crit: cr, exp_lat: lt};
      return v;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_memory_in"}, 32'(memory_in), 32'h0000);
      chk({tag, "_ready"}, 32'(memory_ready), 32'h0);
      chk({tag, "_cur_addr"}, 32'(current_address), 32'hFFFF);
      chk({tag, "_critical"}, 32'(memory_critical), 32'h0);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0000);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0000);
   endtask

   task automatic drain_bus(input string tag);
      bus_t e;
      chk({tag, "_bus_count"}, 32'(obs_n - obs_rd), 32'(exp_bus_q.size()));
      while (obs_rd < obs_n && exp_bus_q.size() > 0) begin
         e = exp_bus_q.pop_front();
         chk({tag, "_bus_we"}, 32'(obs_log[obs_rd].we), 32'(e.we));
         chk({tag, "_bus_addr"}, 32'(obs_log[obs_rd].addr), 32'(e.addr));
         if (e.we) chk({tag, "_bus_wdata"}, 32'(obs_log[obs_rd].wdata), 32'(e.wdata));
         obs_rd = obs_rd + 1;
      end
      exp_bus_q.delete();
      obs_rd = obs_n;
   endtask

   task automatic settle(input string tag, input int lat, input int exp_lat, input int exp_crit);
      rsp_t r;
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      if (exp_rsp_q.size() > 0) begin
         r = exp_rsp_q.pop_front();
         chk({tag, "_memory_in"}, 32'(memory_in), 32'(r.data));
         chk({tag, "_cur_addr"}, 32'(current_address), 32'(r.addr));
      end
      @(negedge clk);
      chk({tag, "_crit_cycles"}, 32'(crit_total - crit_base), 32'(exp_crit));
      drain_bus(tag);
   endtask

   task automatic wait_ready(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat = lat + 1;
      end while (!memory_ready && lat < 400);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      cfg_waits = v.waits;
      cfg_rdata = v.rdata;
      cfg_hold  = v.hold;
      if (v.exp_write) exp_bus_q.push_back('{we: 1'b1, addr: v.addr, wdata: v.data});
      exp_bus_q.push_back('{we: 1'b0, addr: v.exp_fetch, wdata: 16'h0000});
      exp_rsp_q.push_back('{data: v.exp_in, addr: v.exp_cur});
      @(negedge clk);
      crit_base       = crit_total;
      request         = 1'b1;
      request_type    = v.rtype;
      request_address = v.addr;
      store_data      = v.data;
      lat = 0;
      do begin
         @(negedge clk);
         lat = lat + 1;
         if (lat == 1) begin
            chk({tag, "_ready_drop"}, 32'(memory_ready), 32'h0);
            // Poke: a second request lands while the transaction is in flight.
            if (v.poke) begin
               request_type    = 2'b11;
               request_address = 16'h1234;
            end else begin
               request = 1'b0;
            end
         end else begin
            request = 1'b0;
         end
      end while (!memory_ready && lat < 400);
      settle(tag, lat, v.exp_lat, v.exp_crit);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      //            rt     addr      data     w  rdata     h  p  wr fetch     in        cur      cr lat
      vecs[0]  = mk(2'b11, 16'h0005, 16'h0000, 0, 16'h1111, 0, 0, 0, 16'h0005, 16'h1111, 16'h0005, 0, 2);
      vecs[1]  = mk(2'b00, 16'h0000, 16'h0000, 2, 16'h2222, 0, 0, 0, 16'h0006, 16'h2222, 16'h0006, 0, 4);
      vecs[2]  = mk(2'b10, 16'h0100, 16'hBEEF, 0, 16'h3333, 0, 0, 1, 16'h0007, 16'h3333, 16'h0007, 0, 4);
      vecs[3]  = mk(2'b10, 16'hFF10, 16'h1111, 0, 16'h4444, 0, 0, 0, 16'h0008, 16'h4444, 16'h0008, 1, 4);
      vecs[4]  = mk(2'b01, 16'h0200, 16'h0000, 1, 16'h00AA, 0, 0, 0, 16'h0200, 16'h00AA, 16'h0200, 0, 3);
      vecs[5]  = mk(2'b00, 16'h0000, 16'h0000, 0, 16'h5555, 0, 0, 0, 16'h0009, 16'h5555, 16'h0009, 0, 2);
      vecs[6]  = mk(2'b11, 16'h0040, 16'h0000, 0, 16'h6666, 0, 0, 0, 16'h0040, 16'h6666, 16'h0040, 0, 2);
      vecs[7]  = mk(2'b11, 16'hFFFF, 16'h0000, 0, 16'h7777, 0, 0, 0, 16'hFFFF, 16'h7777, 16'hFFFF, 0, 2);
      vecs[8]  = mk(2'b00, 16'h0000, 16'h0000, 0, 16'h8888, 0, 0, 0, 16'h0000, 16'h8888, 16'h0000, 0, 2);
      vecs[9]  = mk(2'b10, 16'hFF00, 16'h2222, 1, 16'h9999, 0, 0, 0, 16'h0001, 16'h9999, 16'h0001, 1, 5);
      vecs[10] = mk(2'b10, 16'hFEFF, 16'h0A0A, 1, 16'hAAAA, 0, 0, 1, 16'h0002, 16'hAAAA, 16'h0002, 0, 6);
      vecs[11] = mk(2'b11, 16'h0007, 16'h0000, 0, 16'h5A5A, 1, 0, 0, 16'h0007, 16'h0000, 16'h0007, 1, 256);
      vecs[12] = mk(2'b00, 16'h0000, 16'h0000, 3, 16'hBBBB, 0, 1, 0, 16'h0008, 16'hBBBB, 16'h0008, 1, 5);
      vecs[13] = mk(2'b00, 16'h0000, 16'h0000, 0, 16'hCCCC, 0, 0, 0, 16'h0009, 16'hCCCC, 16'h0009, 0, 2);

      #1 reset = 1'b0;
      #2 chk_reset("por");

      // Boot: one wait cycle on the first fetch of the reset vector.
      cfg_waits = 1;
      cfg_rdata = 16'h1234;
      exp_bus_q.push_back('{we: 1'b0, addr: 16'h0000, wdata: 16'h0000});
      exp_rsp_q.push_back('{data: 16'h1234, addr: 16'h0000});
      @(negedge clk);
      crit_base = crit_total;
      reset = 1'b1;
      wait_ready(lat);
      settle("boot", lat, 3, 0);

      for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Reset in the middle of a stalled write drops the bus cycle at once.
      cfg_hold = 1'b1;
      exp_bus_q.push_back('{we: 1'b1, addr: 16'h0300, wdata: 16'h1357});
      @(negedge clk);
      request         = 1'b1;
      request_type    = 2'b10;
      request_address = 16'h0300;
      store_data      = 16'h1357;
      @(negedge clk);
      request = 1'b0;
      @(negedge clk);
      chk("midrst_req_before", 32'(mem_req), 32'h1);
      chk("midrst_we_before", 32'(mem_we), 32'h1);
      #2 reset = 1'b0;
      #1 chk_reset("midrst");
      drain_bus("midrst");

      cfg_hold  = 1'b0;
      cfg_waits = 0;
      cfg_rdata = 16'hC0DE;
      exp_bus_q.push_back('{we: 1'b0, addr: 16'h0000, wdata: 16'h0000});
      exp_rsp_q.push_back('{data: 16'hC0DE, addr: 16'h0000});
      @(negedge clk);
      crit_base = crit_total;
      reset = 1'b1;
      wait_ready(lat);
      settle("reboot", lat, 2, 0);
      run_vec(mk(2'b00, 16'h0000, 16'h0000, 0, 16'h0101, 0, 0, 0, 16'h0001, 16'h0101, 16'h0001,
                 0, 2), "after_reboot");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
